// File: rtl/seq_detector_param.sv
// Serial pattern detector: matches a reloadable PAT_W-bit pattern on a qualified bit stream.
// Latency: y is combinational (0 cycles) on the final pattern bit; y_q and match_cnt update at the next edge.
// Backpressure: none; the stream advances only on x_valid, idle cycles hold all state.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   x_valid, x       qualified serial input bit
//   overlap          1 = trailing bits of a match may start the next match
//   pat_load, pat_in load a new pattern (bit PAT_W-1 is received first); restarts detection
//   cnt_clr          synchronous clear of match_cnt, wins over a simultaneous match
//   y, y_q           Mealy match flag and its one-cycle registered copy
//   match_cnt        saturating match counter
module seq_detector_param #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt
);

    // fill only needs to reach PAT_W-1
    localparam int              FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pat;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;

    logic              accepted;
    logic              full;
    logic              match;
    logic [PAT_W-1:0]  shifted;

    always_comb begin
        accepted = x_valid & ~pat_load;
        full     = (fill == FILL_MAX);
        shifted  = {hist, x};
        match    = full && (shifted == pat);
        // rst gates y so the flag drops the moment reset asserts, not at the next edge
        y        = rst & accepted & match;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat       <= DEFAULT_PAT;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            y_q       <= 1'b0;
        end else begin
            y_q <= y;

            if (pat_load) begin
                pat  <= pat_in;
                hist <= '0;
                fill <= '0;
            end else if (accepted) begin
                if (match && !overlap) begin
                    // non-overlapping: the bits of this match cannot be reused
                    hist <= '0;
                    fill <= '0;
                end else begin
                    // keep the newest PAT_W-1 bits; the oldest falls off the top
                    hist <= shifted[PAT_W-2:0];
                    if (!full) begin
                        fill <= fill + 1'b1;
                    end
                end
            end

            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (y && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       x_valid;
    logic       x;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       y;
    logic       y_q;
    logic [7:0] match_cnt;
    logic       y2;
    logic       y_q2;
    logic [1:0] match_cnt2;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1011)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y), .y_q(y_q), .match_cnt(match_cnt)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1011)) dut_small (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y2), .y_q(y_q2), .match_cnt(match_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input at the falling edge and let combinational y settle.
    task automatic step(input logic v, input logic b);
        @(negedge clk);
        x_valid = v;
        x       = b;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        x_valid  = 1'b0;
        x        = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        pat_in   = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Load a pattern with x_valid=1 and x=1 to show the load-cycle bit is ignored.
    task automatic load_pattern(input logic [3:0] p);
        @(negedge clk);
        pat_load = 1'b1;
        pat_in   = p;
        x_valid  = 1'b1;
        x        = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0) begin
            $display("FAIL load_cycle_y: got %b expected 0", y);
            errors++;
        end
        @(posedge clk);
        #1;
        pat_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; x_valid = 1'b1; x = 1'b1; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
        #1;
        checks++;
        if (y !== 1'b0 || y_q !== 1'b0 || match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            $display("FAIL reset_state: got y=%b y_q=%b cnt=%0d cnt2=%0d expected all 0",
                     y, y_q, match_cnt, match_cnt2);
            errors++;
        end
        @(negedge clk);
        rst = 1'b1; x_valid = 1'b0;
    endtask

    task automatic test_stream(input logic ov, input logic [6:0] exp_y, input logic [7:0] exp_cnt);
        logic [6:0] stream;
        logic       prev;
        stream = 7'b1011011;
        prev   = 1'b0;
        apply_reset();
        overlap = ov;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, stream[i]);
            checks++;
            if (y !== exp_y[i]) begin
                $display("FAIL stream_y ov=%0b bit%0d: got %b expected %b", ov, 7 - i, y, exp_y[i]);
                errors++;
            end
            checks++;
            if (y_q !== prev) begin
                $display("FAIL stream_y_q ov=%0b bit%0d: got %b expected %b", ov, 7 - i, y_q, prev);
                errors++;
            end
            prev = exp_y[i];
        end
        @(posedge clk);
        #1;
        checks++;
        if (y_q !== prev || match_cnt !== exp_cnt) begin
            $display("FAIL stream_end ov=%0b: got y_q=%b cnt=%0d expected y_q=%b cnt=%0d",
                     ov, y_q, match_cnt, prev, exp_cnt);
            errors++;
        end
    endtask

    task automatic test_idle();
        logic [3:0] stream;
        stream = 4'b1011;
        apply_reset();
        overlap = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, stream[i]);
            checks++;
            if (y !== (i == 0)) begin
                $display("FAIL idle_valid_y bit%0d: got %b expected %b", 4 - i, y, (i == 0));
                errors++;
            end
            step(1'b0, 1'($urandom));
            checks++;
            if (y !== 1'b0 || y_q !== (i == 0)) begin
                $display("FAIL idle_cycle after bit%0d: got y=%b y_q=%b expected y=0 y_q=%b",
                         4 - i, y, y_q, (i == 0));
                errors++;
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            $display("FAIL idle_cnt: got %0d expected 1", match_cnt);
            errors++;
        end
    endtask

    task automatic test_pat_load();
        logic [2:0] pre;
        pre = 3'b101;
        apply_reset();
        overlap = 1'b1;
        for (int i = 2; i >= 0; i--) step(1'b1, pre[i]);
        load_pattern(4'b1111);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (y !== (i >= 4)) begin
                $display("FAIL load_y one%0d: got %b expected %b", i, y, (i >= 4));
                errors++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (match_cnt !== 8'd2) begin
            $display("FAIL load_cnt: got %0d expected 2", match_cnt);
            errors++;
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        overlap = 1'b1;
        load_pattern(4'b1111);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (y2 !== (i >= 4)) begin
                $display("FAIL sat_y one%0d: got %b expected %b", i, y2, (i >= 4));
                errors++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
            $display("FAIL sat_cnt: got cnt2=%0d cnt=%0d expected cnt2=3 cnt=5", match_cnt2, match_cnt);
            errors++;
        end
        @(negedge clk);
        cnt_clr = 1'b1; x_valid = 1'b1; x = 1'b1;
        #1;
        checks++;
        if (y2 !== 1'b1) begin
            $display("FAIL clr_cycle_y: got %b expected 1", y2);
            errors++;
        end
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if (match_cnt2 !== 2'd0 || match_cnt !== 8'd0) begin
            $display("FAIL clr_wins: got cnt2=%0d cnt=%0d expected 0 and 0", match_cnt2, match_cnt);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        logic [6:0] pre;
        logic [3:0] post;
        pre  = 7'b1011101;
        post = 4'b1011;
        apply_reset();
        overlap = 1'b1;
        for (int i = 6; i >= 0; i--) step(1'b1, pre[i]);
        @(posedge clk);
        #1;
        checks++;
        if (match_cnt !== 8'd1) begin
            $display("FAIL async_pre_cnt: got %0d expected 1", match_cnt);
            errors++;
        end
        // hist now holds 101 with fill full: a 1 would match without the reset pulse
        rst = 1'b0; x_valid = 1'b1; x = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0 || y_q !== 1'b0 || match_cnt !== 8'd0) begin
            $display("FAIL async_reset: got y=%b y_q=%b cnt=%0d expected 0 0 0", y, y_q, match_cnt);
            errors++;
        end
        #2;
        rst = 1'b1;
        step(1'b1, 1'b1);
        checks++;
        if (y !== 1'b0) begin
            $display("FAIL async_after_one: got %b expected 0", y);
            errors++;
        end
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, post[i]);
            checks++;
            if (y !== (i == 0)) begin
                $display("FAIL async_seq bit%0d: got %b expected %b", 4 - i, y, (i == 0));
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream(1'b1, 7'b0001001, 8'd2);
        test_stream(1'b0, 7'b0001000, 8'd1);
        test_idle();
        test_pat_load();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
